// File: rtl/cic_pkg.sv
// Shared definitions for the CIC filter blocks: output-reduction width, parameter range
// checks and a width-generic signed sample type.
package cic_pkg;

  // Widest sample any CIC block carries. Narrower samples live in the low bits.
  localparam int unsigned CIC_MAX_WIDTH = 64;

  typedef logic signed [CIC_MAX_WIDTH-1:0] cic_sample_t;

  // Number of LSBs removed when narrowing the filter output.
  function automatic int unsigned cic_drop(int unsigned w_inp, int unsigned w_out);
    return (w_inp >= w_out) ? (w_inp - w_out) : 0;
  endfunction

  // Legal parameter set for the comb section.
  function automatic bit cic_params_ok(int unsigned w_inp, int unsigned w_out,
                                       int unsigned stages, int unsigned diff_delay);
    return (w_out >= 1) && (w_inp >= w_out) && (w_inp <= CIC_MAX_WIDTH) &&
           (stages >= 1) && (stages <= 8) && (diff_delay >= 1) && (diff_delay <= 4);
  endfunction

  // Interpret the low 'width' bits of a raw vector as a signed sample.
  function automatic cic_sample_t cic_sext(logic [CIC_MAX_WIDTH-1:0] value,
                                           int unsigned width);
    cic_sample_t res;
    res = '0;
    for (int unsigned i = 0; i < CIC_MAX_WIDTH; i++) begin
      res[i] = (i < width) ? value[i] : value[width-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One CIC differentiator: y[n] = x[n] - x[n-DIFF_DELAY], modulo 2^WIDTH.
// Delay line and output register only move on a valid input.
module comb_stage #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DIFF_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] dly_q [DIFF_DELAY];
  logic [WIDTH-1:0] diff;

  // Wrapping subtraction; integrator overflow cancels here.
  assign diff = in_data - dly_q[DIFF_DELAY-1];

  // Delay line, result register and valid flag; clear flushes like reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIFF_DELAY; i++) dly_q[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DIFF_DELAY; i++) dly_q[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= diff;
        dly_q[0] <= in_data;
        for (int i = 1; i < DIFF_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_comb_chain.sv
// CIC decimator comb section: STAGES chained differentiators followed by a registered
// width reduction to DATA_WIDTH_OUT bits.
// Build option: define CIC_COMB_ROUND_EN for round-half-up with positive saturation on
// the output reduction; otherwise the reduction is a plain floor truncation.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_INP = 24,
  parameter int unsigned DATA_WIDTH_OUT = 16,
  parameter int unsigned STAGES         = 3,
  parameter int unsigned DIFF_DELAY     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                             inp_samp_str,
  output logic signed [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                             out_samp_str
);

  localparam int unsigned DROP = cic_drop(DATA_WIDTH_INP, DATA_WIDTH_OUT);

  if (!cic_params_ok(DATA_WIDTH_INP, DATA_WIDTH_OUT, STAGES, DIFF_DELAY)) begin : g_param_err
    $error("cic_comb_chain: illegal parameter set");
  end

  // Index 0 is the chain input; index k is the output of stage k.
  logic [DATA_WIDTH_INP-1:0] stage_data  [STAGES+1];
  logic [STAGES:0]           stage_valid;

  assign stage_data[0]  = inp_samp_data;
  assign stage_valid[0] = inp_samp_str;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    comb_stage #(
      .WIDTH      (DATA_WIDTH_INP),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_data   (stage_data[k]),
      .in_valid  (stage_valid[k]),
      .out_data  (stage_data[k+1]),
      .out_valid (stage_valid[k+1])
    );
  end

  logic [DATA_WIDTH_INP-1:0] chain_out;
  logic [DATA_WIDTH_OUT-1:0] reduced;

  assign chain_out = stage_data[STAGES];

`ifdef CIC_COMB_ROUND_EN
  if (DROP > 0) begin : g_round
    localparam logic [DATA_WIDTH_INP-1:0] HALF    = DATA_WIDTH_INP'(1) << (DROP - 1);
    localparam logic [DATA_WIDTH_OUT-1:0] MAX_POS = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};

    logic [DATA_WIDTH_INP-1:0] sum;
    logic                      ovf;
    logic                      unused_sum_low;

    assign sum            = chain_out + HALF;
    // Adding a positive constant can only overflow from positive to negative.
    assign ovf            = ~chain_out[DATA_WIDTH_INP-1] & sum[DATA_WIDTH_INP-1];
    assign unused_sum_low = ^sum[DROP-1:0];

    // Round half up, clamping to the largest positive code on overflow.
    always_comb begin
      reduced = sum[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
      if (ovf) reduced = MAX_POS;
    end
  end else begin : g_no_round
    assign reduced = chain_out;
  end
`else
  if (DROP > 0) begin : g_trunc
    logic unused_low;
    assign unused_low = ^chain_out[DROP-1:0];
  end
  assign reduced = chain_out[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
`endif

  // Output register: data held between strobes, one strobe per accepted input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else if (clear) begin
      out_samp_data <= '0;
      out_samp_str  <= 1'b0;
    end else begin
      out_samp_str <= stage_valid[STAGES];
      if (stage_valid[STAGES]) out_samp_data <= reduced;
    end
  end

endmodule

// File: doc/cic_comb_chain.md
# cic_comb_chain

Comb section of the CIC decimator: a pipelined chain of STAGES differentiators, each computing y[n] = x[n] − x[n−DIFF_DELAY]. It sits after the decimation strobe generator and consumes the low-rate samples from the integrator chain. It produces the final, width-reduced filter output with a qualifying strobe. Arithmetic is modulo 2^DATA_WIDTH_INP, so integrator overflow cancels exactly.

## Interface
- DATA_WIDTH_INP, 24, width of the input and of every internal stage; must be ≥ DATA_WIDTH_OUT (elaboration error otherwise).
- DATA_WIDTH_OUT, 16, output width.
- STAGES, 3, number of comb stages, 1..8.
- DIFF_DELAY, 1, differential delay M, 1..4.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all state.
- inp_samp_data  in  DATA_WIDTH_INP  signed decimated integrator output.
- inp_samp_str  in  1  input sample valid, single-cycle qualifier.
- out_samp_data  out  DATA_WIDTH_OUT  signed filter output.
- out_samp_str  out  1  output valid, one pulse per accepted input.

## Operation
- Stage k (1..STAGES) owns a DIFF_DELAY-deep delay line and an output register.
- On its input valid, stage k:
  - registers in − dly[M−1];
  - shifts the delay line, with dly[0] ← in.
- The delay line never advances without valid.
- Stage 1 input is inp_samp_data qualified by inp_samp_str. Stage k>1 input is the stage k−1 register qualified by the stage k−1 valid flag.
- Subtraction wraps at DATA_WIDTH_INP bits; there is no saturation inside the chain.
- The output register takes the stage STAGES result and reduces it by DROP = DATA_WIDTH_INP − DATA_WIDTH_OUT bits:
  - without rounding: bits [DATA_WIDTH_INP−1 -: DATA_WIDTH_OUT] (floor);
  - with rounding: see Configuration.
- Valid pipeline: a STAGES+1 bit shift register, so exactly one out_samp_str per inp_samp_str.
- clear, or reset_n low: zeroes all delay lines, stage registers, the valid pipeline and both outputs. In-flight samples are discarded.
- clear and inp_samp_str in the same cycle: clear wins and the sample is dropped.
- Back-to-back strobes on every cycle are supported at full throughput.

## Timing
- Reset values: out_samp_data = 0, out_samp_str = 0; all internal state 0.
- Latency: inp_samp_str at cycle t gives out_samp_str at cycle t+STAGES+1, with data valid in that same cycle.
- out_samp_data holds its value between strobes.
- The first DIFF_DELAY·STAGES outputs after reset or clear reflect zero history. This is expected behaviour, not an error.
- Asynchronous reset mid-pipeline: outputs go to 0 immediately; the next output strobe requires a new input strobe.

## Configuration
- CIC_COMB_ROUND_EN defined:
  - adds 2^(DROP−1) before reduction (round half up);
  - saturates to the maximum positive DATA_WIDTH_OUT value if the addition overflows;
  - no-op when DROP = 0;
  - latency unchanged.
- Undefined: plain truncation (floor), with no adder in the output path.

## Structure
- Shared package cic_pkg:
  - DROP computation function;
  - parameter range checks;
  - the signed sample typedef, parameterised through a width-generic function for the other CIC blocks.
- Sub-module comb_stage: one differentiator containing its delay line, output register and valid flag. It is instantiated STAGES times in a generate loop.
- The top level holds only chaining and the output reduction.

## Test plan
- STAGES=1, M=1, 8→8 bit: strobes with constant 5 → outputs 5, 0, 0, …, first output strobe 2 cycles after first input strobe.
- STAGES=3, M=1: impulse 1 followed by zeros, strobe every cycle → outputs 1, −3, 3, −1, 0, with latency 4.
- Wrap-around, 8-bit, STAGES=1: inputs 127 then −128 → second output 1 (modulo result, no saturation).
- clear asserted with inp_samp_str while 2 samples are in flight → no further out_samp_str; next input 7 after clear → output 7, proving the zeroed history.
- 8→4 bit, STAGES=1, M=1, input 24 after zero:
  - truncation build → 1;
  - CIC_COMB_ROUND_EN build → 2;
  - input 124 with rounding → saturates to 7.
- reset_n pulsed low mid-stream with strobes every cycle → outputs 0 within the same cycle, no strobe until STAGES+1 cycles after the next input.
